// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle LEGv8 control path.
// The opcode patterns are also consumed by the immediate sign-extender.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EX_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EX_R,
    EX_I,
    ALU_WB,
    BRANCH,
    JUMP,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    MEM_LD,
    MEM_ST,
    RTYPE,
    ITYPE,
    CBZ,
    B,
    ILLEGAL
  } op_class_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  // instr[31:21] casez patterns; '?' marks bits belonging to the immediate
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b1001000100?;
  localparam logic [10:0] OP_ANDI = 11'b1001001000?;
  localparam logic [10:0] OP_ORRI = 11'b1011001000?;
  localparam logic [10:0] OP_SUBI = 11'b1101000100?;
  localparam logic [10:0] OP_MOVZ = 11'b110100101??;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;
  localparam logic [10:0] OP_B    = 11'b000101?????;

endpackage

// File: rtl/op_class_dec.sv
// Combinational opcode classifier feeding the control FSM's DECODE state.
module op_class_dec
  import ctrl_pkg::*;
(
  input  logic [10:0] i_opcode,
  output op_class_t   o_class
);

  always_comb begin
    o_class = ILLEGAL;
    casez (i_opcode)
      OP_LDUR: o_class = MEM_LD;
      OP_STUR: o_class = MEM_ST;
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_ORR:  o_class = RTYPE;
      OP_ADDI,
      OP_ANDI,
      OP_ORRI,
      OP_SUBI,
      OP_MOVZ: o_class = ITYPE;
      OP_CBZ:  o_class = CBZ;
      OP_B:    o_class = B;
      default: o_class = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with the unified memory port and counts retired instructions.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [10:0]      i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_pc_src,
  output logic             o_reg_write,
  output logic             o_alu_src,
  output logic             o_mem_to_reg,
  output logic [1:0]       o_alu_op,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_retired
);

  state_t           r_state;
  state_t           w_next;
  op_class_t        r_class;
  op_class_t        w_class;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  op_class_dec u_op_class_dec (
    .i_opcode (i_opcode),
    .o_class  (w_class)
  );

  // The class is captured in DECODE so EX_ADDR and ALU_WB know which path they are on
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= FETCH;
      r_class <= ILLEGAL;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_class <= w_class;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   if (i_mem_ready) w_next = DECODE;
      DECODE: begin
        case (w_class)
          MEM_LD, MEM_ST: w_next = EX_ADDR;
          RTYPE:          w_next = EX_R;
          ITYPE:          w_next = EX_I;
          CBZ:            w_next = BRANCH;
          B:              w_next = JUMP;
          default:        w_next = HALT;
        endcase
      end
      EX_ADDR: w_next = (r_class == MEM_ST) ? MEM_WR : MEM_RD;
      MEM_RD:  if (i_mem_ready) w_next = MEM_WB;
      MEM_WB:  w_next = FETCH;
      MEM_WR:  if (i_mem_ready) w_next = FETCH;
      EX_R:    w_next = ALU_WB;
      EX_I:    w_next = ALU_WB;
      ALU_WB:  w_next = FETCH;
      BRANCH:  w_next = FETCH;
      JUMP:    w_next = FETCH;
      HALT:    w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  // An instruction retires on each entry into FETCH; waiting in FETCH is not an entry
  assign w_retire = (r_state != FETCH) && (w_next == FETCH);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign o_retired = r_retired;

  always_comb begin
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_op     = ALU_ADD;
    o_halted     = 1'b0;
    case (r_state)
      FETCH: begin
        o_mem_read = 1'b1;
        o_ir_write = i_mem_ready;
        o_pc_write = i_mem_ready;
      end
      EX_ADDR: begin
        o_alu_src = 1'b1;
        o_alu_op  = ALU_ADD;
      end
      MEM_RD:  o_mem_read = 1'b1;
      MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      MEM_WR:  o_mem_write = 1'b1;
      EX_R:    o_alu_op = ALU_RTYPE;
      EX_I: begin
        o_alu_src = 1'b1;
        o_alu_op  = ALU_ITYPE;
      end
      // Operand selection is held through writeback so the ALU result stays stable
      ALU_WB: begin
        o_reg_write = 1'b1;
        if (r_class == ITYPE) begin
          o_alu_src = 1'b1;
          o_alu_op  = ALU_ITYPE;
        end else begin
          o_alu_op  = ALU_RTYPE;
        end
      end
      BRANCH: begin
        o_alu_op   = ALU_PASSB;
        o_pc_write = i_zero;
        o_pc_src   = 1'b1;
      end
      JUMP: begin
        o_pc_write = 1'b1;
        o_pc_src   = 1'b1;
      end
      HALT:    o_halted = 1'b1;
      default: o_halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; a CNT_W=4 copy shares the
// stimulus so counter wrap can be observed.
module tb_multicycle_ctrl;

  // Control bus order: mem_read, mem_write, ir_write, pc_write, pc_src,
  // reg_write, alu_src, mem_to_reg, alu_op[1:0], halted
  localparam logic [10:0] C_FETCH_WAIT = 11'b10000000000;
  localparam logic [10:0] C_FETCH_GO   = 11'b10110000000;
  localparam logic [10:0] C_DECODE     = 11'b00000000000;
  localparam logic [10:0] C_EX_R       = 11'b00000000100;
  localparam logic [10:0] C_EX_I       = 11'b00000010110;
  localparam logic [10:0] C_WB_R       = 11'b00000100100;
  localparam logic [10:0] C_WB_I       = 11'b00000110110;
  localparam logic [10:0] C_EX_ADDR    = 11'b00000010000;
  localparam logic [10:0] C_MEM_RD     = 11'b10000000000;
  localparam logic [10:0] C_MEM_WB     = 11'b00000101000;
  localparam logic [10:0] C_MEM_WR     = 11'b01000000000;
  localparam logic [10:0] C_BR_TAKEN   = 11'b00011000010;
  localparam logic [10:0] C_BR_NOT     = 11'b00001000010;
  localparam logic [10:0] C_JUMP       = 11'b00011000000;
  localparam logic [10:0] C_HALT       = 11'b00000000001;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_CBZ  = 11'b10110100101;
  localparam logic [10:0] OPC_B    = 11'b00010100011;
  localparam logic [10:0] OPC_ADDI = 11'b10010001000;
  localparam logic [10:0] OPC_BAD  = 11'b00000000000;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] opcode;
  logic        zero;
  logic        memReady;

  logic        memRead, memWrite, irWrite, pcWrite, pcSrc, regWrite, aluSrc, memToReg, halted;
  logic [1:0]  aluOp;
  logic [31:0] retired;
  logic        memRead4, memWrite4, irWrite4, pcWrite4, pcSrc4, regWrite4, aluSrc4, memToReg4, halted4;
  logic [1:0]  aluOp4;
  logic [3:0]  retired4;

  logic [10:0] ctlBus;
  logic [10:0] ctlBus4;

  int checkCount = 0;
  int errorCount = 0;

  assign ctlBus  = {memRead, memWrite, irWrite, pcWrite, pcSrc, regWrite, aluSrc, memToReg, aluOp, halted};
  assign ctlBus4 = {memRead4, memWrite4, irWrite4, pcWrite4, pcSrc4, regWrite4, aluSrc4, memToReg4, aluOp4, halted4};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .i_clk        (clk),
    .i_reset_n    (resetN),
    .i_opcode     (opcode),
    .i_zero       (zero),
    .i_mem_ready  (memReady),
    .o_mem_read   (memRead),
    .o_mem_write  (memWrite),
    .o_ir_write   (irWrite),
    .o_pc_write   (pcWrite),
    .o_pc_src     (pcSrc),
    .o_reg_write  (regWrite),
    .o_alu_src    (aluSrc),
    .o_mem_to_reg (memToReg),
    .o_alu_op     (aluOp),
    .o_halted     (halted),
    .o_retired    (retired)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .i_clk        (clk),
    .i_reset_n    (resetN),
    .i_opcode     (opcode),
    .i_zero       (zero),
    .i_mem_ready  (memReady),
    .o_mem_read   (memRead4),
    .o_mem_write  (memWrite4),
    .o_ir_write   (irWrite4),
    .o_pc_write   (pcWrite4),
    .o_pc_src     (pcSrc4),
    .o_reg_write  (regWrite4),
    .o_alu_src    (aluSrc4),
    .o_mem_to_reg (memToReg4),
    .o_alu_op     (aluOp4),
    .o_halted     (halted4),
    .o_retired    (retired4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive this cycle's inputs, check the decoded controls, then advance one clock
  task automatic applyStimulus(input string tag, input logic ready, input logic z, input logic [10:0] expCtl);
    memReady = ready;
    zero     = z;
    #1;
    checkOutput(tag, {21'b0, ctlBus}, {21'b0, expCtl});
    checkOutput({tag, "_w4"}, {21'b0, ctlBus4}, {21'b0, expCtl});
    @(posedge clk);
    #1;
  endtask

  task automatic checkRetired(input string tag, input logic [31:0] exp32, input logic [3:0] exp4);
    checkOutput({tag, "_ret"}, retired, exp32);
    checkOutput({tag, "_ret4"}, {28'b0, retired4}, {28'b0, exp4});
  endtask

  task automatic applyReset();
    resetN   = 1'b0;
    memReady = 1'b0;
    #2;
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    resetN   = 1'b0;
    opcode   = OPC_ADD;
    zero     = 1'b0;
    memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    #1;
    checkRetired("reset", 32'd0, 4'd0);
    applyStimulus("reset_fetch", 1'b0, 1'b0, C_FETCH_WAIT);

    // ADD, with a stray mem_ready in DECODE that must be ignored
    opcode = OPC_ADD;
    applyStimulus("add_fetch", 1'b1, 1'b0, C_FETCH_GO);
    applyStimulus("add_decode", 1'b1, 1'b0, C_DECODE);
    applyStimulus("add_ex", 1'b0, 1'b0, C_EX_R);
    checkRetired("add_pre", 32'd0, 4'd0);
    applyStimulus("add_wb", 1'b0, 1'b0, C_WB_R);
    checkRetired("add", 32'd1, 4'd1);

    // LDUR with two wait cycles on the data read
    opcode = OPC_LDUR;
    applyStimulus("ld_fetch", 1'b1, 1'b0, C_FETCH_GO);
    applyStimulus("ld_decode", 1'b0, 1'b0, C_DECODE);
    applyStimulus("ld_exaddr", 1'b0, 1'b0, C_EX_ADDR);
    applyStimulus("ld_rd_wait1", 1'b0, 1'b0, C_MEM_RD);
    applyStimulus("ld_rd_wait2", 1'b0, 1'b0, C_MEM_RD);
    applyStimulus("ld_rd_done", 1'b1, 1'b0, C_MEM_RD);
    applyStimulus("ld_wb", 1'b0, 1'b0, C_MEM_WB);
    checkRetired("ldur", 32'd2, 4'd2);

    opcode = OPC_CBZ;
    applyStimulus("cbz1_fetch", 1'b1, 1'b0, C_FETCH_GO);
    applyStimulus("cbz1_decode", 1'b0, 1'b1, C_DECODE);
    applyStimulus("cbz1_branch", 1'b0, 1'b1, C_BR_TAKEN);
    checkRetired("cbz1", 32'd3, 4'd3);
    applyStimulus("cbz0_fetch", 1'b1, 1'b0, C_FETCH_GO);
    applyStimulus("cbz0_decode", 1'b0, 1'b0, C_DECODE);
    applyStimulus("cbz0_branch", 1'b0, 1'b0, C_BR_NOT);
    checkRetired("cbz0", 32'd4, 4'd4);

    // B with one fetch wait cycle
    opcode = OPC_B;
    applyStimulus("b_fetch_wait", 1'b0, 1'b0, C_FETCH_WAIT);
    applyStimulus("b_fetch", 1'b1, 1'b0, C_FETCH_GO);
    applyStimulus("b_decode", 1'b0, 1'b0, C_DECODE);
    applyStimulus("b_jump", 1'b0, 1'b0, C_JUMP);
    checkRetired("b", 32'd5, 4'd5);

    opcode = OPC_STUR;
    applyStimulus("st_fetch", 1'b1, 1'b0, C_FETCH_GO);
    applyStimulus("st_decode", 1'b0, 1'b0, C_DECODE);
    applyStimulus("st_exaddr", 1'b0, 1'b0, C_EX_ADDR);
    applyStimulus("st_wr", 1'b1, 1'b0, C_MEM_WR);
    checkRetired("stur", 32'd6, 4'd6);

    // Sixteen ADDIs wrap the 4-bit counter
    applyReset();
    #1;
    checkRetired("wrap_start", 32'd0, 4'd0);
    opcode = OPC_ADDI;
    for (int i = 0; i < 16; i++) begin
      applyStimulus("addi_fetch", 1'b1, 1'b0, C_FETCH_GO);
      applyStimulus("addi_decode", 1'b0, 1'b0, C_DECODE);
      applyStimulus("addi_ex", 1'b0, 1'b0, C_EX_I);
      applyStimulus("addi_wb", 1'b0, 1'b0, C_WB_I);
      if (i == 14) checkRetired("wrap15", 32'd15, 4'd15);
    end
    checkRetired("wrap16", 32'd16, 4'd0);

    // Illegal opcode: HALT is terminal and issues no requests
    opcode = OPC_BAD;
    applyStimulus("bad_fetch", 1'b1, 1'b0, C_FETCH_GO);
    applyStimulus("bad_decode", 1'b0, 1'b0, C_DECODE);
    for (int i = 0; i < 20; i++) begin
      applyStimulus("halt", logic'(i % 2), 1'b0, C_HALT);
    end
    checkRetired("halt", 32'd16, 4'd0);
    applyReset();
    applyStimulus("halt_cleared", 1'b0, 1'b0, C_FETCH_WAIT);
    checkRetired("halt_cleared", 32'd0, 4'd0);

    // Reset lands while a store waits on the memory port
    opcode = OPC_STUR;
    applyStimulus("rst_st_fetch", 1'b1, 1'b0, C_FETCH_GO);
    applyStimulus("rst_st_decode", 1'b0, 1'b0, C_DECODE);
    applyStimulus("rst_st_exaddr", 1'b0, 1'b0, C_EX_ADDR);
    applyStimulus("rst_st_wr_wait", 1'b0, 1'b0, C_MEM_WR);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("rst_mw_drop", {31'b0, memWrite}, 32'd0);
    checkOutput("rst_mw_drop_w4", {31'b0, memWrite4}, 32'd0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    applyStimulus("rst_after", 1'b0, 1'b0, C_FETCH_WAIT);
    checkRetired("rst_after", 32'd0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
